// File: rtl/std_fifo_stream_out.sv
// Read-side adapter for std_fifo_sync: issues FIFO reads, tracks in-flight
// words and presents them as a valid/ready stream from a small ring buffer.
module std_fifo_stream_out #(
  parameter int DW     = 8,
  parameter int RD_LAT = 1,
  parameter int BUFD   = RD_LAT + 1,
  parameter int CW     = $clog2(BUFD + 1)
) (
  input  logic          clk,
  input  logic          reset_synced,
  input  logic          clear,
  output logic          fifo_rd_en,
  input  logic          fifo_rd_empty,
  input  logic [DW-1:0] fifo_rd_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] level
);

  localparam int PW = (BUFD > 2) ? $clog2(BUFD) : 1;

  logic [DW-1:0]     mem [BUFD];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     occ;
  logic [RD_LAT-1:0] pipe;
  logic [CW:0]       infl;
  logic [CW:0]       demand;
  logic              cap, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUFD - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    infl = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      infl = infl + (CW+1)'(pipe[i]);
    end
  end

  assign cap     = pipe[RD_LAT-1];
  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = mem[rptr];
  assign level   = occ;

  // Counting the word being popped this cycle as already gone keeps the
  // pipeline full under m_ready=1; pop <= occ so the subtraction never wraps.
  assign demand     = {1'b0, occ} + infl - (CW+1)'(pop);
  assign fifo_rd_en = reset_synced & ~clear & ~fifo_rd_empty &
                      (demand < (CW+1)'(BUFD));

  always_ff @(posedge clk or negedge reset_synced) begin
    if (!reset_synced) begin
      pipe <= '0;
      occ  <= '0;
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < BUFD; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      pipe <= '0;
      occ  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      pipe[0] <= fifo_rd_en;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
      if (cap) begin
        mem[wptr] <= fifo_rd_dout;
        wptr      <= next_ptr(wptr);
      end
      if (pop) begin
        rptr <= next_ptr(rptr);
      end
      case ({cap, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_std_fifo_stream_out.sv
// Bench for std_fifo_stream_out: behavioural FIFO with fixed read latency,
// scoreboard of written words checked against every stream handshake.
module tb_std_fifo_stream_out;

  localparam int DW     = 8;
  localparam int RD_LAT = 2;
  localparam int BUFD   = RD_LAT + 1;
  localparam int CW     = $clog2(BUFD + 1);

  logic          clk = 1'b0;
  logic          reset_synced = 1'b0;
  logic          clear = 1'b0;
  logic          fifo_rd_en;
  logic          fifo_rd_empty;
  logic [DW-1:0] fifo_rd_dout;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] level;

  std_fifo_stream_out #(.DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .reset_synced (reset_synced),
    .clear        (clear),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_dout (fifo_rd_dout),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0]     fifo_mem [256];
  int                wr_idx = 0;
  int                rd_idx = 0;
  logic              fifo_flush = 1'b0;
  logic [DW-1:0]     line [RD_LAT];
  logic [RD_LAT-1:0] line_v;

  logic [DW-1:0] exp_q [$];
  int            pop_cyc [256];
  int            pop_count = 0;
  int            mark;
  int            t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", tag, got, want, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Source FIFO: rd_en at cycle t returns the word at cycle t+RD_LAT.
  assign fifo_rd_empty = (wr_idx == rd_idx);
  assign fifo_rd_dout  = line[RD_LAT-1];

  always @(posedge clk) begin
    if (fifo_flush) rd_idx <= wr_idx;
    else if (fifo_rd_en) rd_idx <= rd_idx + 1;
    line[0] <= fifo_mem[rd_idx[7:0]];
    for (int i = 1; i < RD_LAT; i++) line[i] <= line[i-1];
  end

  // Reads the adapter still owes a slot for (dropped by clear or reset).
  always @(posedge clk or negedge reset_synced) begin
    if (!reset_synced) line_v <= '0;
    else if (clear) line_v <= '0;
    else line_v <= (line_v << 1) | RD_LAT'(fifo_rd_en);
  end

  always @(negedge clk) begin
    if (reset_synced) begin
      check("occ_infl", 32'((32'(level) + 32'($countones(line_v))) <= 32'(BUFD)), 1);
      if (!clear && m_valid && m_ready) begin
        pop_cyc[pop_count] <= cyc;
        pop_count <= pop_count + 1;
        check("pop_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_mem[wr_idx] = w;
    wr_idx++;
    exp_q.push_back(w);
  endtask

  // mode 0: ready high, 1: ready low, 2: ready toggles each cycle
  task automatic run(input int n, input int mode);
    repeat (n) begin
      tick();
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = ~m_ready;
      endcase
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    reset_synced = 1'b1;
    tick();

    // latency and back-to-back delivery of a short burst
    m_ready = 1'b1;
    mark = pop_count;
    push(8'h11); push(8'h22); push(8'h33);
    t0 = cyc;
    @(negedge clk);
    check("t1_rd_en", 32'(fifo_rd_en), 1);
    run(10, 0);
    check("t1_count", 32'(pop_count - mark), 3);
    check("t1_latency", 32'(pop_cyc[mark] - t0), 32'(RD_LAT + 1));
    check("t1_span", 32'(pop_cyc[mark+2] - pop_cyc[mark]), 2);
    check("t1_idle", 32'(m_valid), 0);

    // full throughput
    mark = pop_count;
    for (int i = 0; i < 16; i++) push(8'(i));
    run(30, 0);
    check("t2_count", 32'(pop_count - mark), 16);
    check("t2_span", 32'(pop_cyc[mark+15] - pop_cyc[mark]), 15);
    check("t2_empty", 32'(exp_q.size()), 0);

    // backpressure with a full buffer
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    run(10, 1);
    check("t3_level", 32'(level), 32'(BUFD));
    check("t3_rd_en", 32'(fifo_rd_en), 0);
    check("t3_valid", 32'(m_valid), 1);
    check("t3_data", 32'(m_data), 0);
    run(3, 1);
    check("t3_hold", 32'(m_data), 0);
    check("t3_hold_rd_en", 32'(fifo_rd_en), 0);
    mark = pop_count;
    run(20, 0);
    check("t3_count", 32'(pop_count - mark), 8);
    check("t3_empty", 32'(exp_q.size()), 0);

    // ready toggling every cycle
    m_ready = 1'b1;
    mark = pop_count;
    for (int i = 0; i < 20; i++) push(8'h40 + 8'(i));
    run(70, 2);
    check("t4_count", 32'(pop_count - mark), 20);
    check("t4_empty", 32'(exp_q.size()), 0);

    // clear one cycle after a read issued with two words buffered
    m_ready = 1'b0;
    push(8'h77); push(8'h88);
    run(8, 1);
    check("t5_level", 32'(level), 2);
    tick();
    push(8'h99);
    @(negedge clk);
    check("t5_rd_en", 32'(fifo_rd_en), 1);
    tick();
    clear = 1'b1;
    @(negedge clk);
    check("t5_clr_rd_en", 32'(fifo_rd_en), 0);
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("t5_clr_valid", 32'(m_valid), 0);
    check("t5_clr_level", 32'(level), 0);
    exp_q.delete();
    run(4, 1);
    check("t5_drop_level", 32'(level), 0);
    check("t5_drop_valid", 32'(m_valid), 0);
    m_ready = 1'b1;
    mark = pop_count;
    push(8'h55); push(8'h66);
    run(10, 0);
    check("t5_count", 32'(pop_count - mark), 2);
    check("t5_empty", 32'(exp_q.size()), 0);

    // asynchronous reset mid-burst
    for (int i = 0; i < 10; i++) push(8'hB0 + 8'(i));
    run(5, 0);
    @(posedge clk);
    #3;
    reset_synced = 1'b0;
    #1;
    check("t6_valid", 32'(m_valid), 0);
    check("t6_rd_en", 32'(fifo_rd_en), 0);
    check("t6_level", 32'(level), 0);
    check("t6_data", 32'(m_data), 0);
    exp_q.delete();
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
    tick();
    reset_synced = 1'b1;
    mark = pop_count;
    push(8'hA0); push(8'hA1);
    run(10, 0);
    check("t6_count", 32'(pop_count - mark), 2);
    check("t6_empty", 32'(exp_q.size()), 0);
    check("t6_idle", 32'(m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
